// File: rtl/controller_m_if.sv
// controller_m_if: M-stage bundle between the pipeline and the memory controller.
//   Pipeline -> controller: Instr_E, Flush, Stall, ALUOutput_M, RTV_M, MUXRFWDOut, ForwardRTM
//   Controller -> pipeline: Instr_M, MemWrite, BE, MemWD, LoadType
// master: the side that drives the E-stage inputs; slave: the controller itself.
`timescale 1ns/1ps
interface controller_m_if;
  logic [31:0] Instr_E;
  logic        Flush;
  logic        Stall;
  logic [31:0] ALUOutput_M;
  logic [31:0] RTV_M;
  logic [31:0] MUXRFWDOut;
  logic        ForwardRTM;
  logic [31:0] Instr_M;
  logic        MemWrite;
  logic [3:0]  BE;
  logic [31:0] MemWD;
  logic [2:0]  LoadType;

  modport master (
    output Instr_E, Flush, Stall, ALUOutput_M, RTV_M, MUXRFWDOut, ForwardRTM,
    input  Instr_M, MemWrite, BE, MemWD, LoadType
  );

  modport slave (
    input  Instr_E, Flush, Stall, ALUOutput_M, RTV_M, MUXRFWDOut, ForwardRTM,
    output Instr_M, MemWrite, BE, MemWD, LoadType
  );
endinterface

// File: rtl/controller_m.sv
// controller_m: M-stage instruction register plus data-memory store/load decode.
// Ports:
//   CLK   - rising-edge clock
//   Reset - synchronous active-high reset (clears Instr_M to nop)
//   bus   - controller_m_if.slave: E-stage inputs, store data sources, and the
//           decoded MemWrite / BE / MemWD / LoadType outputs
// Configuration:
//   SUBWORD_STORE_EN - when defined, sh and sb write memory; otherwise only sw writes.
`timescale 1ns/1ps
module controller_m (
  input logic          CLK,
  input logic          Reset,
  controller_m_if.slave bus
);

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpSw  = 6'b101011;
`ifdef SUBWORD_STORE_EN
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSb  = 6'b101000;
`endif

  logic [31:0] instr_m_q;
  logic [5:0]  opcode;
  logic [1:0]  addr_lo;
  logic [31:0] raw_wd;
  logic        mem_write;
  logic [3:0]  be;
  logic [31:0] mem_wd;
  logic [2:0]  load_type;

  // Priority: Reset, then Flush (bubble), then Stall (hold), else advance.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      instr_m_q <= '0;
    end else if (bus.Flush) begin
      instr_m_q <= '0;
    end else if (!bus.Stall) begin
      instr_m_q <= bus.Instr_E;
    end
  end

  assign opcode  = instr_m_q[31:26];
  assign addr_lo = bus.ALUOutput_M[1:0];
  assign raw_wd  = bus.ForwardRTM ? bus.MUXRFWDOut : bus.RTV_M;

  // MemWD defaults to the raw data; it is only lane-replicated when a
  // sub-word store actually writes.
  always_comb begin
    mem_write = 1'b0;
    be        = 4'b0000;
    mem_wd    = raw_wd;
    load_type = 3'd0;
    unique case (opcode)
      OpSw: begin
        if (addr_lo == 2'b00) begin
          mem_write = 1'b1;
          be        = 4'b1111;
        end
      end
`ifdef SUBWORD_STORE_EN
      OpSh: begin
        if (!addr_lo[0]) begin
          mem_write = 1'b1;
          be        = addr_lo[1] ? 4'b1100 : 4'b0011;
          mem_wd    = {2{raw_wd[15:0]}};
        end
      end
      OpSb: begin
        mem_write = 1'b1;
        be        = 4'b0001 << addr_lo;
        mem_wd    = {4{raw_wd[7:0]}};
      end
`endif
      OpLw:    load_type = 3'd1;
      OpLh:    load_type = 3'd2;
      OpLhu:   load_type = 3'd3;
      OpLb:    load_type = 3'd4;
      OpLbu:   load_type = 3'd5;
      default: ;
    endcase
  end

  assign bus.Instr_M  = instr_m_q;
  assign bus.MemWrite = mem_write;
  assign bus.BE       = be;
  assign bus.MemWD    = mem_wd;
  assign bus.LoadType = load_type;

endmodule

// File: tb/tb_controller_m.sv
// tb_controller_m: directed self-checking bench for controller_m.
// Expectations for sh/sb follow SUBWORD_STORE_EN as seen by this compile.
`timescale 1ns/1ps
module tb_controller_m;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  controller_m_if u_if ();

  controller_m u_dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] addr, input logic fwd,
                          input logic [31:0] mux, input logic [31:0] rtv);
    u_if.ALUOutput_M = addr;
    u_if.ForwardRTM  = fwd;
    u_if.MUXRFWDOut  = mux;
    u_if.RTV_M       = rtv;
    #1;
  endtask

  task automatic check_store(input string tag, input logic exp_we, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
    check_val({tag, ".we"}, {31'd0, u_if.MemWrite}, {31'd0, exp_we});
    check_val({tag, ".be"}, {28'd0, u_if.BE}, {28'd0, exp_be});
    check_val({tag, ".wd"}, u_if.MemWD, exp_wd);
    check_val({tag, ".lt"}, {29'd0, u_if.LoadType}, 32'd0);
  endtask

  localparam logic [31:0] ISw  = 32'hAC00_0000;
  localparam logic [31:0] ISh  = 32'hA400_0000;
  localparam logic [31:0] ISb  = 32'hA000_0000;
  localparam logic [31:0] ILhu = 32'h9400_0000;

  logic [31:0] load_ops [5];
  logic [31:0] held;

  initial begin
    n_cmp = 0;
    n_err = 0;
    load_ops[0] = 32'h8C00_0000;  // lw
    load_ops[1] = 32'h8400_0000;  // lh
    load_ops[2] = 32'h9400_0000;  // lhu
    load_ops[3] = 32'h8000_0000;  // lb
    load_ops[4] = 32'h9000_0000;  // lbu

    reset        = 1'b1;
    u_if.Instr_E = ISw;
    u_if.Flush   = 1'b0;
    u_if.Stall   = 1'b0;
    set_data(32'h0, 1'b0, 32'h0, 32'h0);

    // Reset with sw presented: Instr_M must be nop.
    step();
    check_val("rst.instr", u_if.Instr_M, 32'h0);
    check_store("rst", 1'b0, 4'b0000, 32'h0);

    // Aligned / misaligned sw.
    reset = 1'b0;
    step();
    check_val("sw.instr", u_if.Instr_M, ISw);
    set_data(32'h8, 1'b1, 32'hDEAD_BEEF, 32'h1);
    check_store("sw8", 1'b1, 4'b1111, 32'hDEAD_BEEF);
    set_data(32'h9, 1'b1, 32'hDEAD_BEEF, 32'h1);
    check_store("sw9", 1'b0, 4'b0000, 32'hDEAD_BEEF);
    set_data(32'hA, 1'b0, 32'hDEAD_BEEF, 32'h1);
    check_store("swA", 1'b0, 4'b0000, 32'h1);
    set_data(32'h4, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    check_store("sw4", 1'b1, 4'b1111, 32'hCAFE_F00D);

    // sb
    u_if.Instr_E = ISb;
    step();
    set_data(32'h3, 1'b0, 32'hFFFF_FFFF, 32'h0000_00A5);
`ifdef SUBWORD_STORE_EN
    check_store("sb3", 1'b1, 4'b1000, 32'hA5A5_A5A5);
    set_data(32'h0, 1'b1, 32'h0000_013C, 32'h0);
    check_store("sb0", 1'b1, 4'b0001, 32'h3C3C_3C3C);
`else
    check_store("sb3", 1'b0, 4'b0000, 32'h0000_00A5);
`endif

    // sh
    u_if.Instr_E = ISh;
    step();
    set_data(32'h2, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
`ifdef SUBWORD_STORE_EN
    check_store("sh2", 1'b1, 4'b1100, 32'h1234_1234);
    set_data(32'h0, 1'b0, 32'hFFFF_FFFF, 32'hABCD_5678);
    check_store("sh0", 1'b1, 4'b0011, 32'h5678_5678);
`else
    check_store("sh2", 1'b0, 4'b0000, 32'h0000_1234);
`endif
    set_data(32'h1, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
    check_store("sh1", 1'b0, 4'b0000, 32'h0000_1234);

    // Loads decode to LoadType 1..5 with no write.
    set_data(32'h0, 1'b0, 32'h0, 32'h5555_AAAA);
    for (int i = 0; i < 5; i++) begin
      u_if.Instr_E = load_ops[i];
      step();
      check_val($sformatf("ld%0d.lt", i), {29'd0, u_if.LoadType}, i + 1);
      check_val($sformatf("ld%0d.we", i), {31'd0, u_if.MemWrite}, 32'd0);
      check_val($sformatf("ld%0d.be", i), {28'd0, u_if.BE}, 32'd0);
    end

    // Unrelated opcode (addi) and nop.
    u_if.Instr_E = 32'h2000_0000;
    step();
    check_store("addi", 1'b0, 4'b0000, 32'h5555_AAAA);
    u_if.Instr_E = 32'h0;
    step();
    check_store("nop", 1'b0, 4'b0000, 32'h5555_AAAA);

    // Stall holds for two edges while Instr_E changes.
    held = ILhu | 32'h0000_1234;
    u_if.Instr_E = held;
    step();
    check_val("lhu.lt", {29'd0, u_if.LoadType}, 32'd3);
    check_val("lhu.we", {31'd0, u_if.MemWrite}, 32'd0);
    u_if.Stall   = 1'b1;
    u_if.Instr_E = ISw;
    step();
    check_val("stall1", u_if.Instr_M, held);
    u_if.Instr_E = 32'h1234_5678;
    step();
    check_val("stall2", u_if.Instr_M, held);

    // Flush beats Stall.
    u_if.Flush = 1'b1;
    step();
    check_val("flush_stall", u_if.Instr_M, 32'h0);

    // Release: advances again.
    u_if.Flush = 1'b0;
    u_if.Stall = 1'b0;
    u_if.Instr_E = ISw;
    step();
    check_val("release", u_if.Instr_M, ISw);

    // Flush alone inserts a bubble.
    u_if.Flush = 1'b1;
    step();
    check_val("flush", u_if.Instr_M, 32'h0);
    u_if.Flush = 1'b0;

    // Reset discards a stalled instruction and beats Stall.
    step();
    check_val("pre_rst", u_if.Instr_M, ISw);
    u_if.Stall = 1'b1;
    reset = 1'b1;
    step();
    check_val("rst_stall", u_if.Instr_M, 32'h0);
    reset = 1'b0;
    step();
    check_val("stall_after_rst", u_if.Instr_M, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controller_m.md
CONTROLLER_M -- requirements
Module: controller_m

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Instr_E  input  32  instruction leaving the E stage, captured as Instr_M.
REQ-005 Flush  input  1  synchronous bubble insert: loads Instr_M with 0 (nop).
REQ-006 Stall  input  1  holds Instr_M unchanged.
REQ-007 ALUOutput_M  input  32  memory byte address of the M-stage instruction.
REQ-008 RTV_M  input  32  rt value carried from the E stage.
REQ-009 MUXRFWDOut  input  32  forwarded write-back value.
REQ-010 ForwardRTM  input  1  store-data select: 0 = RTV_M, 1 = MUXRFWDOut.
REQ-011 Instr_M  output  32  registered M-stage instruction.
REQ-012 MemWrite  output  1  data-memory write strobe.
REQ-013 BE  output  4  byte-lane enables; bit i covers bits 8i+7:8i.
REQ-014 MemWD  output  32  lane-aligned store data.
REQ-015 LoadType  output  3  load decode: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu.

Function
REQ-016 On a rising edge, Instr_M SHALL take its next value by priority: Reset -> 0; else Flush -> 0; else Stall -> hold; else Instr_E.
REQ-017 Decode SHALL be purely combinational from Instr_M[31:26] and ALUOutput_M[1:0]; all other outputs SHALL be combinational.
REQ-018 Raw store data SHALL equal MUXRFWDOut when ForwardRTM=1, else RTV_M; the selection SHALL be a full 32-bit 2:1 mux with no gating.
REQ-019 sw (opcode 101011): if addr[1:0]=00, then MemWrite=1, BE=1111, and MemWD=raw data; otherwise MemWrite=0 and BE=0000 (misaligned store suppressed).
REQ-020 sh (opcode 101001): if addr[0]=0, then MemWrite=1 and BE=0011 (addr[1]=0) or BE=1100 (addr[1]=1); MemWD SHALL hold raw[15:0] replicated into both halves; if addr[0]=1, then MemWrite=0 and BE=0000.
REQ-021 sb (opcode 101000): MemWrite=1, BE=one-hot at bit addr[1:0], and MemWD SHALL hold raw[7:0] replicated into all four bytes.
REQ-022 Loads: opcodes 100011, 100001, 100101, 100000, 100100 SHALL map to LoadType 1 through 5 respectively, with MemWrite=0 and BE=0000.
REQ-023 For every other opcode, including nop (Instr_M=0): MemWrite=0, BE=0000, LoadType=0.
REQ-024 When MemWrite=0, MemWD SHALL still equal the raw selected data; MemWrite=0 SHALL always imply BE=0000.
REQ-025 If Flush and Stall are asserted together, Flush SHALL win.

Reset
REQ-026 Under Reset, Instr_M SHALL become 0 on the next edge, which forces MemWrite=0, BE=0000, and LoadType=0; Reset SHALL take priority over Flush and Stall.
REQ-027 A reset mid-operation SHALL discard any held (stalled) instruction.

Configuration
REQ-028 Macro SUBWORD_STORE_EN: when defined, sh and sb SHALL decode per REQ-020 and REQ-021.
REQ-029 When SUBWORD_STORE_EN is undefined, sh and sb SHALL decode as no-ops (MemWrite=0, BE=0000), and only sw SHALL write.

Verification
REQ-030 Reset=1 for one edge with Instr_E=sw -> Instr_M=0, MemWrite=0.
REQ-031 sw, addr 0x0000_0008, ForwardRTM=1, MUXRFWDOut=0xDEADBEEF, RTV_M=0x1 -> MemWrite=1, BE=1111, MemWD=0xDEADBEEF; same with addr 0x9 -> MemWrite=0, BE=0000.
REQ-032 With SUBWORD_STORE_EN defined: sb, addr 0x3, RTV_M=0x000000A5, ForwardRTM=0 -> BE=1000, MemWD=0xA5A5A5A5; sh, addr 0x2, RTV_M=0x1234 -> BE=1100, MemWD=0x12341234.
REQ-033 Without SUBWORD_STORE_EN: the same sb instruction -> MemWrite=0, BE=0000.
REQ-034 Stall=1 for 2 edges with Instr_E changing -> Instr_M unchanged; Flush=1 and Stall=1 together -> Instr_M=0 on the next edge.
REQ-035 lhu in Instr_M -> LoadType=3, MemWrite=0.
